// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the byte-enable data memory.
package data_memory_pkg;

    // Controller states: zero-fill sweep, or serving requests.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int BYTE_W = 8;

    // The merge helper works on a fixed wide word so one function serves every
    // word width; callers zero-extend their operands and keep the low W bits.
    // Word widths must therefore stay below MERGE_W_MAX.
    localparam int MERGE_W_MAX  = 1024;
    localparam int MERGE_BE_MAX = MERGE_W_MAX / BYTE_W;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic logic [MERGE_W_MAX-1:0] byte_merge(
        input logic [MERGE_W_MAX-1:0]  old_word,
        input logic [MERGE_W_MAX-1:0]  new_word,
        input logic [MERGE_BE_MAX-1:0] be
    );
        logic [MERGE_W_MAX-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MERGE_BE_MAX; i++) begin
            if (be[i]) begin
                merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_memory_read_pipe.sv
// Read-response delay line: LAT-1 {valid, data} stages behind the array
// output register. Each stage only loads data alongside a valid token, so the
// final stage holds the last returned word while no response is pending.
module data_memory_read_pipe #(
    parameter int LAT = 1,
    parameter int W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o
);

    if (LAT == 1) begin : g_wire
        // The array register already provides single-cycle latency.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign out_valid_o    = in_valid_i;
        assign out_data_o     = in_data_i;
    end else begin : g_pipe
        for (genvar gi = 0; gi < LAT - 1; gi++) begin : g_stage
            logic         valid_q;
            logic [W-1:0] data_q;
            logic         prev_valid;
            logic [W-1:0] prev_data;

            if (gi == 0) begin : g_first
                assign prev_valid = in_valid_i;
                assign prev_data  = in_data_i;
            end else begin : g_next
                assign prev_valid = g_stage[gi-1].valid_q;
                assign prev_data  = g_stage[gi-1].data_q;
            end

            // Shift the token along; reset drops every token in flight.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= prev_valid;
                    if (prev_valid) begin
                        data_q <= prev_data;
                    end
                end
            end
        end

        assign out_valid_o = g_stage[LAT-2].valid_q;
        assign out_data_o  = g_stage[LAT-2].data_q;
    end

endmodule

// File: rtl/data_memory_be.sv
// Single-port data memory with byte-enable writes, a registered read path of
// LAT cycles (1..3) and a hardware zero-fill sweep after reset or on clear.
// W must be a multiple of 8. One request per cycle, served strictly in order.
module data_memory_be
    import data_memory_pkg::*;
#(
    parameter int D   = 6,
    parameter int W   = 32,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic [D-1:0]   req_addr,
    input  logic [W-1:0]   req_wdata,
    input  logic [W/8-1:0] req_be,
    output logic           resp_valid,
    output logic [W-1:0]   resp_rdata
);

    localparam int DEPTH = 1 << D;

    logic [W-1:0] mem_q [DEPTH];

    state_t       state_q;
    logic [D-1:0] sweep_cnt_q;
    logic         req_ready_q;

    logic         rd_valid_q;
    logic [W-1:0] rd_data_q;

    logic         accept_d;
    logic         rd_accept_d;
    logic         wr_accept_d;

    logic         mem_we_d;
    logic [D-1:0] mem_waddr_d;
    logic [W-1:0] mem_wdata_d;

    logic [MERGE_W_MAX-1:0] merge_wide;
    logic                   merge_unused;

    // req_ready_q is only ever high in READY, so it gates acceptance directly.
    assign accept_d    = req_valid & req_ready_q & ~rst;
    assign rd_accept_d = accept_d & ~req_write;
    assign wr_accept_d = accept_d & req_write;

    assign merge_wide   = byte_merge(MERGE_W_MAX'(mem_q[req_addr]),
                                     MERGE_W_MAX'(req_wdata),
                                     MERGE_BE_MAX'(req_be));
    assign merge_unused = ^merge_wide[MERGE_W_MAX-1:W];

    // Controller: sweep every address once, then serve requests until clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            sweep_cnt_q <= '0;
            req_ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    sweep_cnt_q <= sweep_cnt_q + 1'b1;
                    if (sweep_cnt_q == {D{1'b1}}) begin
                        state_q     <= READY;
                        req_ready_q <= 1'b1;
                    end
                end
                READY: begin
                    if (clear) begin
                        state_q     <= CLEAR;
                        sweep_cnt_q <= '0;
                        req_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= CLEAR;
                    sweep_cnt_q <= '0;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Single write port shared by the sweep and by accepted request writes;
    // the two never coincide because requests are refused during the sweep.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = req_addr;
        mem_wdata_d = merge_wide[W-1:0];
        if (!rst && state_q == CLEAR) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = sweep_cnt_q;
            mem_wdata_d = '0;
        end else if (wr_accept_d) begin
            mem_we_d    = 1'b1;
        end
    end

    // Array write; storage itself is not reset, the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    // Registered array read: captures the word as of the acceptance edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_accept_d;
            if (rd_accept_d) begin
                rd_data_q <= mem_q[req_addr];
            end
        end
    end

    data_memory_read_pipe #(
        .LAT (LAT),
        .W   (W)
    ) u_read_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (rd_valid_q),
        .in_data_i   (rd_data_q),
        .out_valid_o (resp_valid),
        .out_data_o  (resp_rdata)
    );

    assign req_ready = req_ready_q;

endmodule

// File: tb/tb_data_memory_be.sv
// Bench for data_memory_be: one LAT=1 and one LAT=3 instance share the same
// request stimulus; a scoreboard per instance holds expected data and arrival
// cycle for each read.
`timescale 1ns/1ps
module tb_data_memory_be;

    localparam int D = 6;
    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         clear     = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_write = 1'b0;
    logic [D-1:0] req_addr  = '0;
    logic [W-1:0] req_wdata = '0;
    logic [3:0]   req_be    = '0;

    logic         ready1, rv1, ready3, rv3;
    logic [W-1:0] rd1, rd3;

    always #5 clk = ~clk;

    data_memory_be #(.D(D), .W(W), .LAT(1)) u_dut_lat1 (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (ready1),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (rv1),
        .resp_rdata (rd1)
    );

    data_memory_be #(.D(D), .W(W), .LAT(3)) u_dut_lat3 (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (ready3),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (rv3),
        .resp_rdata (rd3)
    );

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t         q1[$];
    exp_t         q3[$];
    exp_t         e1, e3;
    logic [W-1:0] model_mem [64];

    int   cyc       = 0;
    logic rst_seen  = 1'b1;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   resp3_cnt = 0;
    logic [W-1:0] last1 = '0;
    logic [W-1:0] last3 = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // LAT=1 response monitor
    always @(negedge clk) begin
        if (rst_seen) begin
            check("lat1_rst_valid", {31'b0, rv1}, 32'd0);
            check("lat1_rst_data", rd1, 32'd0);
            last1 = '0;
        end else if (rv1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("lat1_extra_resp", {31'b0, rv1}, 32'd0);
            end else begin
                e1 = q1.pop_front();
                $display("resp lat1 data=%08h cyc=%0d", rd1, cyc);
                check("lat1_data", rd1, e1.data);
                check("lat1_cycle", cyc, e1.due);
            end
            last1 = rd1;
        end else begin
            check("lat1_hold", rd1, last1);
            if (q1.size() > 0 && q1[0].due < cyc) begin
                check("lat1_missing", cyc, q1[0].due);
                void'(q1.pop_front());
            end
        end
    end

    // LAT=3 response monitor
    always @(negedge clk) begin
        if (rst_seen) begin
            check("lat3_rst_valid", {31'b0, rv3}, 32'd0);
            check("lat3_rst_data", rd3, 32'd0);
            last3 = '0;
        end else if (rv3 === 1'b1) begin
            resp3_cnt++;
            if (q3.size() == 0) begin
                check("lat3_extra_resp", {31'b0, rv3}, 32'd0);
            end else begin
                e3 = q3.pop_front();
                $display("resp lat3 data=%08h cyc=%0d", rd3, cyc);
                check("lat3_data", rd3, e3.data);
                check("lat3_cycle", cyc, e3.due);
            end
            last3 = rd3;
        end else begin
            check("lat3_hold", rd3, last3);
            if (q3.size() > 0 && q3[0].due < cyc) begin
                check("lat3_missing", cyc, q3[0].due);
                void'(q3.pop_front());
            end
        end
    end

    task automatic zero_model();
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
    endtask

    // Drive one request at the next falling edge; it is accepted at the
    // following rising edge. Reads push their expected word and arrival cycle.
    task automatic issue(input logic wr, input logic [D-1:0] a, input logic [W-1:0] d,
                         input logic [3:0] be, input bit to3);
        @(negedge clk);
        check("req_ready", {31'b0, ready1}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
            end
        end else begin
            q1.push_back('{model_mem[a], cyc + 1});
            if (to3) q3.push_back('{model_mem[a], cyc + 3});
        end
        $display("req %s addr=%0d data=%08h be=%b", wr ? "WR" : "RD", a, d, be);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_write = 1'b0;
        end
    endtask

    // Called at the falling edge right after the edge that starts a sweep.
    // Counts cycles until req_ready returns; optionally pulses clear mid-sweep.
    task automatic measure_sweep(input string tag, input int pulse_at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            clear = (n == pulse_at);
            if (n == 63) begin
                check({tag, "_ready1_low"}, {31'b0, ready1}, 32'd0);
                check({tag, "_ready3_low"}, {31'b0, ready3}, 32'd0);
            end
        end while (ready1 !== 1'b1 && n < 200);
        clear = 1'b0;
        check({tag, "_sweep_len"}, n, 32'd64);
        check({tag, "_ready3_high"}, {31'b0, ready3}, 32'd1);
        $display("sweep %s done after %0d cycles", tag, n);
    endtask

    initial begin
        int base3;
        zero_model();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready1", {31'b0, ready1}, 32'd0);
        check("rst_ready3", {31'b0, ready3}, 32'd0);
        rst = 1'b0;
        measure_sweep("init", 0);

        // Top address is zero after the sweep
        issue(1'b0, 6'h3F, '0, 4'h0, 1'b1);
        idle(1);

        // Full-word write, read on the very next cycle
        issue(1'b1, 6'd5, 32'hDEADBEEF, 4'hF, 1'b1);
        issue(1'b0, 6'd5, '0, 4'h0, 1'b1);
        idle(1);

        // Byte-enable merge onto a zeroed word
        issue(1'b1, 6'd7, 32'h11223344, 4'b0101, 1'b1);
        issue(1'b0, 6'd7, '0, 4'h0, 1'b1);
        idle(1);

        // Write with no byte enables changes nothing
        issue(1'b1, 6'd5, 32'h01234567, 4'h0, 1'b1);
        issue(1'b0, 6'd5, '0, 4'h0, 1'b1);
        idle(1);

        // Back-to-back reads
        issue(1'b1, 6'd1, 32'h10101010, 4'hF, 1'b1);
        issue(1'b1, 6'd2, 32'h20202020, 4'hF, 1'b1);
        issue(1'b1, 6'd3, 32'h30303030, 4'hF, 1'b1);
        issue(1'b0, 6'd1, '0, 4'h0, 1'b1);
        issue(1'b0, 6'd2, '0, 4'h0, 1'b1);
        issue(1'b0, 6'd3, '0, 4'h0, 1'b1);
        idle(1);

        // Clear in the same cycle as a read of addr 4
        issue(1'b1, 6'd4, 32'hA5A5A5A5, 4'hF, 1'b1);
        idle(2);
        issue(1'b0, 6'd4, '0, 4'h0, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        req_valid = 1'b0;
        zero_model();
        measure_sweep("clear", 0);
        issue(1'b0, 6'd4, '0, 4'h0, 1'b1);
        idle(1);

        // Mixed random traffic over a small address window
        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op == 0) begin
                idle(1);
            end else if (op == 1) begin
                issue(1'b1, 6'($urandom_range(0, 15)), $urandom,
                      4'($urandom_range(0, 15)), 1'b1);
            end else begin
                issue(1'b0, 6'($urandom_range(0, 15)), '0, 4'h0, 1'b1);
            end
        end
        idle(4);

        // Reset with two LAT=3 reads in flight: they must vanish
        issue(1'b1, 6'd10, 32'hCAFEF00D, 4'hF, 1'b1);
        issue(1'b1, 6'd11, 32'h0BADBEEF, 4'hF, 1'b1);
        base3 = resp3_cnt;
        issue(1'b0, 6'd10, '0, 4'h0, 1'b0);
        issue(1'b0, 6'd11, '0, 4'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        zero_model();
        measure_sweep("rst_midop", 20);
        check("rst_drop_lat3", resp3_cnt - base3, 32'd0);
        issue(1'b0, 6'd10, '0, 4'h0, 1'b1);
        idle(6);

        check("drain_lat1", q1.size(), 32'd0);
        check("drain_lat3", q3.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
